// File: rtl/sobel_window_pkg.sv
// sobel_window_pkg: shared FSM state, pixel width and window tap indices for sobel_window
package sobel_window_pkg;
  localparam int PIX_W = 8;
  typedef enum logic {IDLE, ACTIVE} state_e;
  localparam int TAP_Z0 = 0;
  localparam int TAP_Z1 = 1;
  localparam int TAP_Z2 = 2;
  localparam int TAP_Z3 = 3;
  localparam int TAP_Z4 = 4;
  localparam int TAP_Z5 = 5;
  localparam int TAP_Z6 = 6;
  localparam int TAP_Z7 = 7;
  localparam int TAP_Z8 = 8;
endpackage

// File: rtl/sobel_window_line_buffer.sv
// sobel_window_line_buffer: DEPTH x 8 line memory, synchronous read, read-before-write on address collision
module sobel_window_line_buffer
  import sobel_window_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int AW    = 10
) (
  input  logic             clk_i,
  input  logic [AW-1:0]    raddr_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [PIX_W-1:0] wdata_i,
  output logic [PIX_W-1:0] rdata_o
);
  logic [PIX_W-1:0] mem_q [DEPTH];
  // registered read returns the pre-write contents so the block maps onto block RAM
  always_ff @(posedge clk_i) begin
    rdata_o <= mem_q[raddr_i];
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end
endmodule

// File: rtl/sobel_window.sv
// sobel_window: 3x3 streaming window generator for the Sobel stage; `define SOBEL_WIN_ZEROPAD_EN for zero-padded borders
module sobel_window
  import sobel_window_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int COL_W      = 10,
  parameter int ROW_W      = 9
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [PIX_W-1:0] pix_in_i,
  input  logic             pix_valid_i,
  input  logic             sof_i,
  output logic [PIX_W-1:0] z0_o,
  output logic [PIX_W-1:0] z1_o,
  output logic [PIX_W-1:0] z2_o,
  output logic [PIX_W-1:0] z3_o,
  output logic [PIX_W-1:0] z4_o,
  output logic [PIX_W-1:0] z5_o,
  output logic [PIX_W-1:0] z6_o,
  output logic [PIX_W-1:0] z7_o,
  output logic [PIX_W-1:0] z8_o,
  output logic             win_valid_o,
  output logic [ROW_W-1:0] win_row_o,
  output logic [COL_W-1:0] win_col_o,
  output logic             frame_done_o
);
  state_e           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d, cur_row, s1_row_q, wrow_q;
  logic [COL_W-1:0] col_q, col_d, cur_col, s1_col_q, wcol_q;
  logic             proc, col_end, last, win_ok;
  logic             s1_proc_q, s1_win_q, s1_last_q, win_valid_q, frame_done_q;
  logic [PIX_W-1:0] s1_pix_q, lb1_rd, lb2_rd;
  logic [PIX_W-1:0] win_q [9];
  logic [PIX_W-1:0] win_d [9];
  logic [PIX_W-1:0] z_q [9];
  // frame position tracking: sof forces (0,0) in either state, last pixel returns to IDLE
  always_comb begin
    proc    = pix_valid_i && (sof_i || state_q == ACTIVE);
    cur_row = sof_i ? '0 : row_q;
    cur_col = sof_i ? '0 : col_q;
    col_end = cur_col == COL_W'(IMG_WIDTH - 1);
    last    = col_end && cur_row == ROW_W'(IMG_HEIGHT - 1);
    state_d = proc ? (last ? IDLE : ACTIVE) : state_q;
    col_d   = proc ? (col_end ? '0 : cur_col + COL_W'(1)) : col_q;
    row_d   = proc ? (last ? '0 : (col_end ? cur_row + ROW_W'(1) : cur_row)) : row_q;
`ifdef SOBEL_WIN_ZEROPAD_EN
    win_ok  = proc;
`else
    win_ok  = proc && cur_row >= ROW_W'(2) && cur_col >= COL_W'(2);
`endif
  end
  // FSM state and next-pixel position
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end
  sobel_window_line_buffer #(.DEPTH(IMG_WIDTH), .AW(COL_W)) u_lb1 (
    .clk_i   (clk_i),
    .raddr_i (cur_col),
    .we_i    (proc),
    .waddr_i (cur_col),
    .wdata_i (pix_in_i),
    .rdata_o (lb1_rd)
  );
  // lb2 takes the old lb1 word one cycle later, once the synchronous read has returned it
  sobel_window_line_buffer #(.DEPTH(IMG_WIDTH), .AW(COL_W)) u_lb2 (
    .clk_i   (clk_i),
    .raddr_i (cur_col),
    .we_i    (s1_proc_q),
    .waddr_i (s1_col_q),
    .wdata_i (lb1_rd),
    .rdata_o (lb2_rd)
  );
  // stage aligned with the line-buffer read data
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_proc_q <= 1'b0;
      s1_win_q  <= 1'b0;
      s1_last_q <= 1'b0;
      s1_pix_q  <= '0;
      s1_row_q  <= '0;
      s1_col_q  <= '0;
    end else begin
      s1_proc_q <= proc;
      s1_win_q  <= win_ok;
      s1_last_q <= proc && last;
      s1_pix_q  <= pix_in_i;
      s1_row_q  <= cur_row;
      s1_col_q  <= cur_col;
    end
  end
  // column shift of the three window rows, newest column entering on the right
  always_comb begin
    win_d = win_q;
    if (s1_proc_q) begin
      win_d[TAP_Z0] = win_q[TAP_Z1];
      win_d[TAP_Z1] = win_q[TAP_Z2];
      win_d[TAP_Z2] = lb2_rd;
      win_d[TAP_Z3] = win_q[TAP_Z4];
      win_d[TAP_Z4] = win_q[TAP_Z5];
      win_d[TAP_Z5] = lb1_rd;
      win_d[TAP_Z6] = win_q[TAP_Z7];
      win_d[TAP_Z7] = win_q[TAP_Z8];
      win_d[TAP_Z8] = s1_pix_q;
`ifdef SOBEL_WIN_ZEROPAD_EN
      win_d[TAP_Z2] = s1_row_q < ROW_W'(2) ? '0 : lb2_rd;
      win_d[TAP_Z5] = s1_row_q == '0 ? '0 : lb1_rd;
      if (s1_col_q == '0) begin
        win_d[TAP_Z0] = '0;
        win_d[TAP_Z1] = '0;
        win_d[TAP_Z3] = '0;
        win_d[TAP_Z4] = '0;
        win_d[TAP_Z6] = '0;
        win_d[TAP_Z7] = '0;
      end
`endif
    end
  end
  // window shift registers plus output registers that only load on a strobe
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      win_q        <= '{default: '0};
      z_q          <= '{default: '0};
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      wrow_q       <= '0;
      wcol_q       <= '0;
    end else begin
      win_q        <= win_d;
      win_valid_q  <= s1_win_q;
      frame_done_q <= s1_last_q;
      if (s1_win_q) begin
        z_q    <= win_d;
        wrow_q <= s1_row_q;
        wcol_q <= s1_col_q;
      end
    end
  end
  assign z0_o         = z_q[TAP_Z0];
  assign z1_o         = z_q[TAP_Z1];
  assign z2_o         = z_q[TAP_Z2];
  assign z3_o         = z_q[TAP_Z3];
  assign z4_o         = z_q[TAP_Z4];
  assign z5_o         = z_q[TAP_Z5];
  assign z6_o         = z_q[TAP_Z6];
  assign z7_o         = z_q[TAP_Z7];
  assign z8_o         = z_q[TAP_Z8];
  assign win_valid_o  = win_valid_q;
  assign win_row_o    = wrow_q;
  assign win_col_o    = wcol_q;
  assign frame_done_o = frame_done_q;
endmodule

// File: tb/tb_sobel_window.sv
// tb_sobel_window: randomized self-checking bench for sobel_window against an image-array reference model
module tb_sobel_window;
  localparam int W = 4;
  localparam int H = 4;
`ifdef SOBEL_WIN_ZEROPAD_EN
  localparam bit PAD  = 1'b1;
  localparam int NWIN = 16;
`else
  localparam bit PAD  = 1'b0;
  localparam int NWIN = 4;
`endif
  logic clk, rst, pix_valid, sof;
  logic [7:0] pix_in, z0, z1, z2, z3, z4, z5, z6, z7, z8;
  logic win_valid, frame_done;
  logic [1:0] win_row, win_col;
  logic [77:0] obs;
  sobel_window #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .COL_W(2), .ROW_W(2)) dut (
    .clk_i(clk), .rst_i(rst), .pix_in_i(pix_in), .pix_valid_i(pix_valid), .sof_i(sof),
    .z0_o(z0), .z1_o(z1), .z2_o(z2), .z3_o(z3), .z4_o(z4), .z5_o(z5), .z6_o(z6), .z7_o(z7), .z8_o(z8),
    .win_valid_o(win_valid), .win_row_o(win_row), .win_col_o(win_col), .frame_done_o(frame_done)
  );
  assign obs = {win_valid, frame_done, win_row, win_col, z0, z1, z2, z3, z4, z5, z6, z7, z8};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {bit r; bit v; bit s; logic [7:0] p;} stim_t;
  stim_t stim[$];
  int errors = 0, checks = 0, n_win, n_done;
  bit m_act, d_v, d_done, e_v, e_done;
  int m_r, m_c, d_row, d_col, e_row, e_col;
  logic [7:0] img [H][W];
  logic [7:0] d_z [9];
  logic [7:0] e_z [9];
  function automatic logic [77:0] exp_vec();
    return {e_v, e_done, 2'(e_row), 2'(e_col), e_z[0], e_z[1], e_z[2], e_z[3], e_z[4], e_z[5], e_z[6], e_z[7], e_z[8]};
  endfunction
  task automatic model_reset();
    m_act = 0; d_v = 0; d_done = 0; e_v = 0; e_done = 0; e_row = 0; e_col = 0;
    d_row = 0; d_col = 0;
    for (int i = 0; i < 9; i++) begin d_z[i] = 0; e_z[i] = 0; end
  endtask
  task automatic model_step(bit v, bit s, logic [7:0] p);
    int r, c, rr, cc;
    e_v = d_v;
    e_done = d_done;
    if (d_v) begin e_row = d_row; e_col = d_col; e_z = d_z; end
    d_v = 0; d_done = 0;
    if (v && (s || m_act)) begin
      r = s ? 0 : m_r;
      c = s ? 0 : m_c;
      img[r][c] = p;
      if (PAD || (r >= 2 && c >= 2)) begin
        d_v = 1; d_row = r; d_col = c; d_done = (r == H - 1 && c == W - 1);
        for (int k = 0; k < 9; k++) begin
          rr = r - 2 + k / 3;
          cc = c - 2 + k % 3;
          d_z[k] = (rr < 0 || cc < 0) ? 8'h00 : img[rr][cc];
        end
      end
      m_act = !(r == H - 1 && c == W - 1);
      m_c = (c == W - 1) ? 0 : c + 1;
      m_r = (c == W - 1) ? r + 1 : r;
    end
  endtask
  task automatic cycle(stim_t x);
    rst = x.r; pix_valid = x.v; sof = x.s; pix_in = x.p;
    if (x.r) model_reset();
    @(posedge clk);
    if (!x.r) model_step(x.v, x.s, x.p);
    @(negedge clk);
  endtask
  task automatic add_idle(int n);
    for (int i = 0; i < n; i++) stim.push_back('{0, 0, 1'($urandom), 8'($urandom)});
  endtask
  task automatic add_frame(int base, bit rnd, int gapmax, int stop);
    for (int i = 0; i < W * H; i++) begin
      if (i == stop) return;
      add_idle(gapmax > 0 ? $urandom_range(0, gapmax) : 0);
      stim.push_back('{0, 1, i == 0, rnd ? 8'($urandom) : 8'(base + 16 * (i / W) + i % W)});
    end
  endtask
  task automatic test_reset();
    #1 rst = 1; pix_valid = 0; sof = 0; pix_in = 0;
    model_reset();
    #1 checks++;
    if (obs !== 78'h0) begin errors++; $display("FAIL reset_async: got %h want 0", obs); end
    @(negedge clk);
    stim.delete();
    stim.push_back('{1, 0, 0, 0});
    stim.push_back('{1, 1, 1, 8'h55});
    add_idle(3);
    foreach (stim[i]) begin
      cycle(stim[i]); checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL reset_hold cyc%0d: got %h want %h", i, obs, exp_vec()); end
    end
  endtask
  task automatic test_frame();
    logic [77:0] first_o, last_o;
    bit got = 0;
    stim.delete(); add_frame(0, 0, 0, -1); add_idle(3);
    n_win = 0; n_done = 0; first_o = 0; last_o = 0;
    foreach (stim[i]) begin
      cycle(stim[i]); checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL frame cyc%0d: got %h want %h", i, obs, exp_vec()); end
      if (win_valid && !got) begin first_o = obs; got = 1; end
      if (win_valid) last_o = obs;
      n_win += int'(win_valid); n_done += int'(frame_done);
    end
    checks += 4;
`ifdef SOBEL_WIN_ZEROPAD_EN
    if (first_o !== {1'b1, 1'b0, 4'h0, 72'h0}) begin errors++; $display("FAIL frame_first: got %h want origin window", first_o); end
`else
    if (first_o !== {1'b1, 1'b0, 2'd2, 2'd2, 72'h00_01_02_10_11_12_20_21_22}) begin errors++; $display("FAIL frame_first: got %h", first_o); end
`endif
    if ({last_o[76], last_o[7:0]} !== 9'h133) begin errors++; $display("FAIL frame_last: got done=%b z8=%h want 1/33", last_o[76], last_o[7:0]); end
    if (n_win !== NWIN) begin errors++; $display("FAIL frame_count: got %0d want %0d", n_win, NWIN); end
    if (n_done !== 1) begin errors++; $display("FAIL frame_done_count: got %0d want 1", n_done); end
  endtask
  task automatic test_gaps();
    stim.delete(); add_frame(0, 0, 5, -1); add_frame(0, 1, 5, -1); add_idle(4);
    n_win = 0; n_done = 0;
    foreach (stim[i]) begin
      cycle(stim[i]); checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL gaps cyc%0d: got %h want %h", i, obs, exp_vec()); end
      n_win += int'(win_valid); n_done += int'(frame_done);
    end
    checks += 2;
    if (n_win !== 2 * NWIN) begin errors++; $display("FAIL gaps_count: got %0d want %0d", n_win, 2 * NWIN); end
    if (n_done !== 2) begin errors++; $display("FAIL gaps_done_count: got %0d want 2", n_done); end
  endtask
  task automatic test_resync();
    logic [11:0] first_o;
    bit got = 0;
    stim.delete(); add_frame(0, 0, 0, W + 2); add_frame(8'h80, 0, 0, -1); add_idle(3);
    n_win = 0; n_done = 0; first_o = 0;
    foreach (stim[i]) begin
      cycle(stim[i]); checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL resync cyc%0d: got %h want %h", i, obs, exp_vec()); end
      if (win_valid && !got) begin first_o = {win_row, win_col, z0}; got = 1; end
      n_win += int'(win_valid); n_done += int'(frame_done);
    end
    checks += 3;
    if (first_o !== (PAD ? 12'h000 : 12'hA80)) begin errors++; $display("FAIL resync_first: got %h want %h", first_o, PAD ? 12'h000 : 12'hA80); end
    if (n_win !== NWIN + (PAD ? W + 2 : 0)) begin errors++; $display("FAIL resync_count: got %0d want %0d", n_win, NWIN + (PAD ? W + 2 : 0)); end
    if (n_done !== 1) begin errors++; $display("FAIL resync_done_count: got %0d want 1", n_done); end
  endtask
  task automatic test_reset_mid();
    stim.delete(); add_frame(0, 0, 0, 2 * W + 3);
    foreach (stim[i]) begin
      cycle(stim[i]); checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL rstmid_pre cyc%0d: got %h want %h", i, obs, exp_vec()); end
    end
    rst = 1; pix_valid = 1; sof = 0; pix_in = 8'h23;
    model_reset();
    #1 checks++;
    if (obs !== 78'h0) begin errors++; $display("FAIL rstmid_async: got %h want 0", obs); end
    @(negedge clk);
    stim.delete();
    stim.push_back('{1, 1, 0, 8'h23});
    for (int i = 0; i < 8; i++) stim.push_back('{0, 1, 0, 8'($urandom)});
    add_idle(3);
    n_win = 0; n_done = 0;
    foreach (stim[i]) begin
      cycle(stim[i]); checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL rstmid_post cyc%0d: got %h want %h", i, obs, exp_vec()); end
      n_win += int'(win_valid); n_done += int'(frame_done);
    end
    checks++;
    if (n_win + n_done !== 0) begin errors++; $display("FAIL rstmid_nosof_strobes: got %0d want 0", n_win + n_done); end
    stim.delete(); add_frame(0, 1, 2, -1); add_idle(3);
    n_win = 0;
    foreach (stim[i]) begin
      cycle(stim[i]); checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL rstmid_recover cyc%0d: got %h want %h", i, obs, exp_vec()); end
      n_win += int'(win_valid);
    end
    checks++;
    if (n_win !== NWIN) begin errors++; $display("FAIL rstmid_recover_count: got %0d want %0d", n_win, NWIN); end
  endtask
  task automatic test_idle_nosof();
    stim.delete();
    for (int i = 0; i < 10; i++) stim.push_back('{0, 1, 0, 8'($urandom)});
    add_idle(3);
    n_win = 0; n_done = 0;
    foreach (stim[i]) begin
      cycle(stim[i]); checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL idle_nosof cyc%0d: got %h want %h", i, obs, exp_vec()); end
      n_win += int'(win_valid); n_done += int'(frame_done);
    end
    checks++;
    if (n_win + n_done !== 0) begin errors++; $display("FAIL idle_nosof_strobes: got %0d want 0", n_win + n_done); end
  endtask
  task automatic test_back_to_back();
    stim.delete(); add_frame(0, 1, 0, -1); add_frame(0, 1, 0, -1); add_frame(0, 1, 0, -1); add_idle(3);
    n_win = 0; n_done = 0;
    foreach (stim[i]) begin
      cycle(stim[i]); checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL b2b cyc%0d: got %h want %h", i, obs, exp_vec()); end
      n_win += int'(win_valid); n_done += int'(frame_done);
    end
    checks += 2;
    if (n_win !== 3 * NWIN) begin errors++; $display("FAIL b2b_count: got %0d want %0d", n_win, 3 * NWIN); end
    if (n_done !== 3) begin errors++; $display("FAIL b2b_done_count: got %0d want 3", n_done); end
  endtask
  initial begin
    rst = 0; pix_valid = 0; sof = 0; pix_in = 0;
    test_reset();
    test_frame();
    test_gaps();
    test_resync();
    test_reset_mid();
    test_idle_nosof();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
